// File: rtl/zacore_mem_pkg.sv
// Shared types for the zacore instruction/data memory: port FSM states,
// latency counter type and the default memory depth.
package zacore_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } port_state_e;

  typedef logic [3:0] lat_cnt_t;

  localparam int DEFAULT_DEPTH_WORDS = 16384;

endpackage

// File: rtl/zacore_memory_if.sv
// Fetch and data handshake bundle between a core (master) and zacore_memory (slave).
interface zacore_memory_if;

  logic        i_fetch_req;
  logic        o_fetch_ack;
  logic [31:0] i_fetch_addr;
  logic [31:0] o_inst_read;

  logic        i_read_req;
  logic        i_write_req;
  logic        o_read_ack;
  logic        o_write_ack;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_write;
  logic [3:0]  i_data_write_mask;
  logic [31:0] o_data_read;

  modport master (
    output i_fetch_req, i_fetch_addr,
    output i_read_req, i_write_req, i_data_addr, i_data_write, i_data_write_mask,
    input  o_fetch_ack, o_inst_read, o_read_ack, o_write_ack, o_data_read
  );

  modport slave (
    input  i_fetch_req, i_fetch_addr,
    input  i_read_req, i_write_req, i_data_addr, i_data_write, i_data_write_mask,
    output o_fetch_ack, o_inst_read, o_read_ack, o_write_ack, o_data_read
  );

endinterface

// File: rtl/zacore_mem_port_fsm.sv
// Request/ack sequencer for one memory port: accepts in IDLE, waits out the
// latency in BUSY, pulses ack for one cycle in ACK.
module zacore_mem_port_fsm
  import zacore_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic req,
  output logic accept,
  output logic commit,
  output logic ack
);

  port_state_e state, next_state;
  lat_cnt_t    cnt, next_cnt;

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values and
    // simulation order between always_ff blocks cannot change the result.
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // commit marks the edge entering ACK, where the memory access takes effect.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept   = 1'b1;
          next_cnt = lat_cnt_t'(LATENCY - 1);
          if (LATENCY == 1) begin
            next_state = ACK;
            commit     = 1'b1;
          end else begin
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= lat_cnt_t'(1)) begin
          next_state = ACK;
          next_cnt   = '0;
          commit     = 1'b1;
        end else begin
          next_cnt = cnt - lat_cnt_t'(1);
        end
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // A reset edge drops any transaction, including one due to commit now.
    if (i_rst) begin
      accept = 1'b0;
      commit = 1'b0;
    end
  end

  assign ack = (state == ACK);

endmodule

// File: rtl/zacore_memory.sv
// Dual-port word memory: independent fetch (read-only) and data (read/write,
// byte-masked, write-priority) ports with configurable fixed latency.
module zacore_memory
  import zacore_mem_pkg::*;
#(
  parameter int DEPTH_WORDS   = DEFAULT_DEPTH_WORDS,
  parameter int FETCH_LATENCY = 1,
  parameter int DATA_LATENCY  = 1,
  parameter     INIT_FILE     = ""
) (
  input logic            i_clk,
  input logic            i_rst,
  zacore_memory_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // NOTE: the array has no reset; contents survive i_rst and it maps to block RAM.
  logic [31:0] mem [DEPTH_WORDS];

  logic          f_accept, f_commit, f_ack;
  logic          d_accept, d_commit, d_ack;
  logic [AW-1:0] f_addr_q, f_addr;
  logic [AW-1:0] d_addr_q, d_addr;
  logic [31:0]   d_wdata_q, d_wdata;
  logic [3:0]    d_mask_q, d_mask;
  logic          d_is_write_q, d_is_write;
  logic [31:0]   inst_read_q, data_read_q;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{bus.i_fetch_addr[31:AW], bus.i_data_addr[31:AW]};

  zacore_mem_port_fsm #(.LATENCY(FETCH_LATENCY)) u_fetch_fsm (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req    (bus.i_fetch_req),
    .accept (f_accept),
    .commit (f_commit),
    .ack    (f_ack)
  );

  // Write-priority selector: a write wins in IDLE; a held read is taken later.
  zacore_mem_port_fsm #(.LATENCY(DATA_LATENCY)) u_data_fsm (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req    (bus.i_write_req | bus.i_read_req),
    .accept (d_accept),
    .commit (d_commit),
    .ack    (d_ack)
  );

  always_ff @(posedge i_clk) begin
    if (f_accept) f_addr_q <= bus.i_fetch_addr[AW-1:0];
    if (d_accept) begin
      d_addr_q     <= bus.i_data_addr[AW-1:0];
      d_wdata_q    <= bus.i_data_write;
      d_mask_q     <= bus.i_data_write_mask;
      d_is_write_q <= bus.i_write_req;
    end
  end

  // With latency 1 acceptance and commit share an edge, so use the live inputs.
  assign f_addr     = f_accept ? bus.i_fetch_addr[AW-1:0] : f_addr_q;
  assign d_addr     = d_accept ? bus.i_data_addr[AW-1:0]  : d_addr_q;
  assign d_wdata    = d_accept ? bus.i_data_write         : d_wdata_q;
  assign d_mask     = d_accept ? bus.i_data_write_mask    : d_mask_q;
  assign d_is_write = d_accept ? bus.i_write_req          : d_is_write_q;

  always_ff @(posedge i_clk) begin
    if (d_commit && d_is_write) begin
      for (int k = 0; k < 4; k++) begin
        if (d_mask[k]) mem[d_addr][8*k +: 8] <= d_wdata[8*k +: 8];
      end
    end
  end

  // Read ports see the pre-edge word, so a same-edge write returns old data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inst_read_q <= '0;
      data_read_q <= '0;
    end else begin
      if (f_commit)                data_read_q <= data_read_q;
      if (f_commit)                inst_read_q <= mem[f_addr];
      if (d_commit && !d_is_write) data_read_q <= mem[d_addr];
    end
  end

  assign bus.o_fetch_ack = f_ack;
  assign bus.o_inst_read = inst_read_q;
  assign bus.o_read_ack  = d_ack & ~d_is_write_q;
  assign bus.o_write_ack = d_ack & d_is_write_q;
  assign bus.o_data_read = data_read_q;

endmodule

// File: tb/tb_zacore_memory.sv
// Directed bench for zacore_memory: a data-port vector table on one instance
// plus hand-written latency, priority, collision, hold and reset sequences.
module tb_zacore_memory;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  zacore_memory_if bus_a ();
  zacore_memory_if bus_b ();

  zacore_memory #(.DEPTH_WORDS(16384), .FETCH_LATENCY(1), .DATA_LATENCY(3)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst_a),
    .bus   (bus_a.slave)
  );

  zacore_memory #(.DEPTH_WORDS(16384), .FETCH_LATENCY(2), .DATA_LATENCY(4)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b.slave)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 fetch ack, 1 read ack, 2 write ack
  function automatic logic ack_of(input bit sel, input int kind);
    case (kind)
      0:       return sel ? bus_b.o_fetch_ack : bus_a.o_fetch_ack;
      1:       return sel ? bus_b.o_read_ack  : bus_a.o_read_ack;
      default: return sel ? bus_b.o_write_ack : bus_a.o_write_ack;
    endcase
  endfunction

  task automatic drive_data(input bit sel, input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask);
    if (sel) begin
      bus_b.i_write_req = wr; bus_b.i_read_req = rd; bus_b.i_data_addr = addr;
      bus_b.i_data_write = wdata; bus_b.i_data_write_mask = mask;
    end else begin
      bus_a.i_write_req = wr; bus_a.i_read_req = rd; bus_a.i_data_addr = addr;
      bus_a.i_data_write = wdata; bus_a.i_data_write_mask = mask;
    end
  endtask

  task automatic wait_ack(input bit sel, input int kind, inout int lat);
    while (!ack_of(sel, kind) && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic data_op(input bit sel, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, output logic [31:0] rdata, output int lat);
    lat = 0;
    drive_data(sel, wr, !wr, addr, wdata, mask);
    wait_ack(sel, wr ? 2 : 1, lat);
    rdata = sel ? bus_b.o_data_read : bus_a.o_data_read;
    drive_data(sel, 1'b0, 1'b0, addr, wdata, mask);
    step();
    check("data_ack_pulse", {31'd0, ack_of(sel, wr ? 2 : 1)}, 32'd0);
  endtask

  task automatic fetch_op(input bit sel, input logic [31:0] addr, output logic [31:0] data, output int lat);
    lat = 0;
    if (sel) begin bus_b.i_fetch_req = 1'b1; bus_b.i_fetch_addr = addr; end
    else     begin bus_a.i_fetch_req = 1'b1; bus_a.i_fetch_addr = addr; end
    wait_ack(sel, 0, lat);
    data = sel ? bus_b.o_inst_read : bus_a.o_inst_read;
    if (sel) bus_b.i_fetch_req = 1'b0; else bus_a.i_fetch_req = 1'b0;
    step();
    check("fetch_ack_pulse", {31'd0, ack_of(sel, 0)}, 32'd0);
  endtask

  task automatic check_idle_outputs(input bit sel, input string tag);
    check({tag, "_fetch_ack"}, {31'd0, ack_of(sel, 0)}, 32'd0);
    check({tag, "_read_ack"},  {31'd0, ack_of(sel, 1)}, 32'd0);
    check({tag, "_write_ack"}, {31'd0, ack_of(sel, 2)}, 32'd0);
    check({tag, "_inst_read"}, sel ? bus_b.o_inst_read : bus_a.o_inst_read, 32'd0);
    check({tag, "_data_read"}, sel ? bus_b.o_data_read : bus_a.o_data_read, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, lat2, n, first, second;

    vecs[0]  = '{1'b1, 32'd7,       32'h1111_1111, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 32'd7,       32'hAABB_CCDD, 4'h5, 32'h0};
    vecs[2]  = '{1'b0, 32'd7,       32'h0,         4'h0, 32'h11BB_11DD};
    vecs[3]  = '{1'b1, 32'd7,       32'hFFFF_FFFF, 4'h0, 32'h0};
    vecs[4]  = '{1'b0, 32'd7,       32'h0,         4'h0, 32'h11BB_11DD};
    vecs[5]  = '{1'b1, 32'd2,       32'hCAFE_0002, 4'hF, 32'h0};
    vecs[6]  = '{1'b0, 32'd16386,   32'h0,         4'h0, 32'hCAFE_0002};
    vecs[7]  = '{1'b1, 32'h0000_400A, 32'h0A0A_0A0A, 4'hF, 32'h0};
    vecs[8]  = '{1'b0, 32'd10,      32'h0,         4'h0, 32'h0A0A_0A0A};
    vecs[9]  = '{1'b1, 32'd5,       32'h1234_5678, 4'hF, 32'h0};
    vecs[10] = '{1'b1, 32'd3,       32'h3333_0000, 4'hF, 32'h0};
    vecs[11] = '{1'b1, 32'd10,      32'h5566_7788, 4'hA, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_400A, 32'h0,       4'h0, 32'h550A_770A};

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.i_fetch_req = 1'b0; bus_a.i_fetch_addr = '0;
    bus_b.i_fetch_req = 1'b0; bus_b.i_fetch_addr = '0;
    drive_data(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    drive_data(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    repeat (3) step();
    check_idle_outputs(1'b0, "reset_a");
    check_idle_outputs(1'b1, "reset_b");
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 13; i++) begin
      data_op(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask, rd, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      if (!vecs[i].wr) check($sformatf("vec%0d_read", i), rd, vecs[i].exp);
    end

    fetch_op(1'b0, 32'd5, rd, lat);
    check("fetch5_latency", 32'(lat), 32'd1);
    check("fetch5_data", rd, 32'h1234_5678);

    // Simultaneous write and read to addr 9: write first, read after.
    drive_data(1'b0, 1'b1, 1'b1, 32'd9, 32'hDEAD_BEEF, 4'hF);
    lat = 0;
    while (!bus_a.o_write_ack && !bus_a.o_read_ack && lat < 20) begin step(); lat++; end
    check("prio_write_latency", 32'(lat), 32'd3);
    check("prio_write_ack", {31'd0, bus_a.o_write_ack}, 32'd1);
    check("prio_read_not_yet", {31'd0, bus_a.o_read_ack}, 32'd0);
    bus_a.i_write_req = 1'b0;
    lat2 = 0;
    wait_ack(1'b0, 1, lat2);
    check("prio_read_gap", 32'(lat2), 32'd4);
    check("prio_read_data", bus_a.o_data_read, 32'hDEAD_BEEF);
    bus_a.i_read_req = 1'b0;
    step();

    // Address change after acceptance is ignored.
    drive_data(1'b0, 1'b0, 1'b1, 32'd7, 32'd0, 4'h0);
    step();
    bus_a.i_data_addr = 32'd9;
    lat = 1;
    wait_ack(1'b0, 1, lat);
    check("addr_change_latency", 32'(lat), 32'd3);
    check("addr_change_data", bus_a.o_data_read, 32'h11BB_11DD);
    bus_a.i_read_req = 1'b0;
    step();

    // Write request dropped before ack still completes.
    drive_data(1'b0, 1'b1, 1'b0, 32'd12, 32'h0C0C_0C0C, 4'hF);
    step();
    bus_a.i_write_req = 1'b0;
    lat = 1;
    wait_ack(1'b0, 2, lat);
    check("dropped_req_latency", 32'(lat), 32'd3);
    step();
    data_op(1'b0, 1'b0, 32'd12, 32'd0, 4'h0, rd, lat);
    check("dropped_req_data", rd, 32'h0C0C_0C0C);
    check("data_read_hold", bus_a.o_data_read, 32'h0C0C_0C0C);

    // Fetch and write of addr 3 committing on the same edge.
    drive_data(1'b0, 1'b1, 1'b0, 32'd3, 32'h4444_4444, 4'hF);
    step();
    step();
    bus_a.i_fetch_req = 1'b1; bus_a.i_fetch_addr = 32'd3;
    step();
    check("collide_write_ack", {31'd0, bus_a.o_write_ack}, 32'd1);
    check("collide_fetch_ack", {31'd0, bus_a.o_fetch_ack}, 32'd1);
    check("collide_old_word", bus_a.o_inst_read, 32'h3333_0000);
    bus_a.i_fetch_req = 1'b0; bus_a.i_write_req = 1'b0;
    step();
    check("inst_read_hold", bus_a.o_inst_read, 32'h3333_0000);
    fetch_op(1'b0, 32'd3, rd, lat);
    check("collide_new_word", rd, 32'h4444_4444);

    // Held fetch request: acks every 2 cycles.
    bus_a.i_fetch_req = 1'b1; bus_a.i_fetch_addr = 32'd5;
    n = 0; first = -1; second = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus_a.o_fetch_ack) begin
        n++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    bus_a.i_fetch_req = 1'b0;
    step();
    check("hold_fetch_count", 32'(n), 32'd4);
    check("hold_fetch_spacing", 32'(second - first), 32'd2);
    check("hold_fetch_data", bus_a.o_inst_read, 32'h1234_5678);

    // Held read request on a wrapped address: acks every 4 cycles.
    drive_data(1'b0, 1'b0, 1'b1, 32'd16386, 32'd0, 4'h0);
    n = 0; first = -1; second = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus_a.o_read_ack) begin
        n++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    bus_a.i_read_req = 1'b0;
    step();
    check("hold_read_count", 32'(n), 32'd2);
    check("hold_read_spacing", 32'(second - first), 32'd4);
    check("hold_read_data", bus_a.o_data_read, 32'hCAFE_0002);

    // Instance B (data latency 4): reset in the middle of a write.
    data_op(1'b1, 1'b1, 32'd4, 32'h0000_0044, 4'hF, rd, lat);
    check("b_write_latency", 32'(lat), 32'd4);
    fetch_op(1'b1, 32'd4, rd, lat);
    check("b_fetch_latency", 32'(lat), 32'd2);
    check("b_fetch_data", rd, 32'h0000_0044);
    data_op(1'b1, 1'b0, 32'd4, 32'd0, 4'h0, rd, lat);
    check("b_read_data", rd, 32'h0000_0044);

    drive_data(1'b1, 1'b1, 1'b0, 32'd4, 32'h9999_9999, 4'hF);
    step();
    step();
    rst_b = 1'b1;
    bus_b.i_write_req = 1'b0;
    step();
    check_idle_outputs(1'b1, "midrst");
    step();
    check("midrst_no_write_ack", {31'd0, bus_b.o_write_ack}, 32'd0);
    rst_b = 1'b0;
    drive_data(1'b1, 1'b0, 1'b1, 32'd4, 32'd0, 4'h0);
    lat = 0;
    wait_ack(1'b1, 1, lat);
    check("post_rst_first_accept", 32'(lat), 32'd4);
    check("post_rst_word_unchanged", bus_b.o_data_read, 32'h0000_0044);
    bus_b.i_read_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
